// File: rtl/btn_pkg.sv
// btn_pkg: channel states and board timing constants shared by the button input path.
package btn_pkg;
    typedef enum logic [2:0] {IDLE, DB_PRESS, PRESSED, HELD, DB_REL} btn_state_e;
    localparam int CLK_HZ = 27_000_000;
    localparam int DEBOUNCE_10MS = CLK_HZ / 100;
    localparam int LONG_1S = CLK_HZ;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce FSM and hold/repeat counters for one button.
// Auto-repeat is built only when BUTTON_REPEAT_EN is defined.
module button_channel
    import btn_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int REPEAT_CYCLES   = LONG_1S / 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int W = $clog2(max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES));
    localparam logic REL_LVL = (ACTIVE_LOW != 0);
    btn_state_e state_q;
    logic [1:0] sync_q;
    logic [W-1:0] cnt_q, hold_q;
    logic held_q, act;
    assign act = sync_q[1] ^ REL_LVL;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= {2{REL_LVL}};
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            held_q    <= 1'b0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            case (state_q)
                IDLE: if (act) begin
                    state_q <= DB_PRESS;
                    cnt_q   <= '0;
                end
                DB_PRESS: if (!act) state_q <= IDLE;
                else if (cnt_q == W'(DEBOUNCE_CYCLES - 1)) begin
                    state_q <= PRESSED;
                    press_o <= 1'b1;
                    level_o <= 1'b1;
                    hold_q  <= '0;
                    held_q  <= 1'b0;
                end else cnt_q <= cnt_q + 1'b1;
                // the long-press threshold takes precedence over a release in the same cycle
                PRESSED: if (hold_q == W'(LONG_CYCLES - 1)) begin
                    state_q <= HELD;
                    long_o  <= 1'b1;
                    held_q  <= 1'b1;
                end else if (!act) begin
                    state_q <= DB_REL;
                    cnt_q   <= '0;
                end else hold_q <= hold_q + 1'b1;
                HELD: if (!act) begin
                    state_q <= DB_REL;
                    cnt_q   <= '0;
                end
                DB_REL: if (act) state_q <= held_q ? HELD : PRESSED;
                else if (cnt_q == W'(DEBOUNCE_CYCLES - 1)) begin
                    state_q   <= IDLE;
                    release_o <= 1'b1;
                    level_o   <= 1'b0;
                end else cnt_q <= cnt_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef BUTTON_REPEAT_EN
    logic [W-1:0] rep_q;
    logic rep_last;
    assign rep_last = (rep_q == W'(REPEAT_CYCLES - 1));
    // rep_q holds its value across DB_REL so a bounce while held keeps the cadence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q    <= '0;
            repeat_o <= 1'b0;
        end else begin
            repeat_o <= 1'b0;
            if (state_q == HELD && act) begin
                rep_q    <= rep_last ? '0 : rep_q + 1'b1;
                repeat_o <= rep_last;
            end else if (state_q != DB_REL) rep_q <= '0;
        end
    end
`else
    assign repeat_o = 1'b0;
`endif
endmodule

// File: rtl/button_input.sv
// button_input: N_BTN independent debounced button channels with press/release/long/repeat events.
// Optional auto-repeat via BUTTON_REPEAT_EN.
module button_input
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int LONG_CYCLES     = LONG_1S,
    parameter int REPEAT_CYCLES   = LONG_1S / 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_repeat
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (btn[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i]),
            .long_o   (btn_long[i]),
            .repeat_o (btn_repeat[i])
        );
    end
endmodule

// File: tb/tb_button_input.sv
// tb_button_input: scoreboard bench; expected pulses are queued with their cycle when stimulus is driven.
module tb_button_input;
    typedef struct {int cyc; int kind; int ch;} ev_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] btn = 2'b11;
    logic [1:0] btn_level, btn_press, btn_release, btn_long, btn_repeat;
    logic [3:0][1:0] pl;
    logic [9:0] outs;
    int cyc = 0, compared = 0, fails = 0, idx;
    ev_t exp_q[$];
    string names[4] = '{"press", "release", "long", "repeat"};

    button_input #(.N_BTN(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .btn(btn), .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long), .btn_repeat(btn_repeat));

    assign pl = {btn_repeat, btn_long, btn_release, btn_press};
    assign outs = {btn_level, btn_press, btn_release, btn_long, btn_repeat};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 2; c++)
                if (pl[k][c]) begin
                    idx = -1;
                    foreach (exp_q[j]) if (idx < 0 && exp_q[j].kind == k && exp_q[j].ch == c) idx = j;
                    compared++;
                    if (idx < 0) begin
                        fails++;
                        $display("FAIL unexpected %s[%0d]: got pulse at cycle %0d, required none", names[k], c, cyc);
                    end else begin
                        if (exp_q[idx].cyc !== cyc) begin
                            fails++;
                            $display("FAIL %s[%0d] timing: got cycle %0d, required %0d", names[k], c, cyc, exp_q[idx].cyc);
                        end
                        exp_q.delete(idx);
                    end
                end
        for (int j = exp_q.size() - 1; j >= 0; j--)
            if (exp_q[j].cyc < cyc) begin
                compared++;
                fails++;
                $display("FAIL missing %s[%0d]: got no pulse, required at cycle %0d", names[exp_q[j].kind], exp_q[j].ch, exp_q[j].cyc);
                exp_q.delete(j);
            end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        btn = 2'b11;
        rst = 1'b1;
        wait_cyc(3);
        compared++;
        if (outs !== '0) begin fails++; $display("FAIL reset_during: got %b, required 0", outs); end
        rst = 1'b0;
        wait_cyc(50);
        compared++;
        if (outs !== '0) begin fails++; $display("FAIL reset_after: got %b, required 0", outs); end
    endtask

    task automatic test_clean_press();
        int c;
        @(negedge clk);
        c = cyc;
        btn[0] = 1'b0;
        exp_q.push_back('{c + 7, 0, 0});
        wait_cyc(8);
        compared++;
        if (btn_level !== 2'b01) begin fails++; $display("FAIL press_level: got %b, required 01", btn_level); end
        btn[0] = 1'b1;
        exp_q.push_back('{c + 15, 1, 0});
        wait_cyc(10);
        compared++;
        if (btn_level !== 2'b00) begin fails++; $display("FAIL release_level: got %b, required 00", btn_level); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            btn[0] = (i % 2 == 1);
            wait_cyc(2);
        end
        btn[0] = 1'b1;
        wait_cyc(10);
        compared++;
        if (btn_level !== 2'b00) begin fails++; $display("FAIL bounce_level: got %b, required 00", btn_level); end
    endtask

    task automatic test_long_press();
        int c;
        @(negedge clk);
        c = cyc;
        btn[0] = 1'b0;
        exp_q.push_back('{c + 7, 0, 0});
        exp_q.push_back('{c + 17, 2, 0});
`ifdef BUTTON_REPEAT_EN
        for (int t = c + 20; t <= c + 32; t += 3) exp_q.push_back('{t, 3, 0});
`endif
        wait_cyc(30);
        btn[0] = 1'b1;
        exp_q.push_back('{c + 37, 1, 0});
        wait_cyc(3);
        compared++;
        if (btn_level !== 2'b01) begin fails++; $display("FAIL held_level: got %b, required 01", btn_level); end
        wait_cyc(10);
        compared++;
        if (btn_level !== 2'b00) begin fails++; $display("FAIL long_release_level: got %b, required 00", btn_level); end
    endtask

    task automatic test_long_release_tie();
        int c;
        @(negedge clk);
        c = cyc;
        btn[0] = 1'b0;
        exp_q.push_back('{c + 7, 0, 0});
        exp_q.push_back('{c + 17, 2, 0});
        exp_q.push_back('{c + 22, 1, 0});
        wait_cyc(14);
        btn[0] = 1'b1;
        wait_cyc(12);
        compared++;
        if (btn_level !== 2'b00) begin fails++; $display("FAIL tie_level: got %b, required 00", btn_level); end
    endtask

    task automatic test_back_to_back();
        int c;
        @(negedge clk);
        c = cyc;
        btn = 2'b00;
        exp_q.push_back('{c + 7, 0, 0});
        exp_q.push_back('{c + 7, 0, 1});
        wait_cyc(9);
        compared++;
        if (btn_level !== 2'b11) begin fails++; $display("FAIL both_level: got %b, required 11", btn_level); end
        btn = 2'b11;
        exp_q.push_back('{c + 16, 1, 0});
        exp_q.push_back('{c + 16, 1, 1});
        wait_cyc(10);
        compared++;
        if (btn_level !== 2'b00) begin fails++; $display("FAIL both_release_level: got %b, required 00", btn_level); end
    endtask

    task automatic test_reset_mid_press();
        int c, r;
        @(negedge clk);
        c = cyc;
        btn[0] = 1'b0;
        exp_q.push_back('{c + 7, 0, 0});
        wait_cyc(10);
        compared++;
        if (btn_level !== 2'b01) begin fails++; $display("FAIL mid_level: got %b, required 01", btn_level); end
        rst = 1'b1;
        #1;
        compared++;
        if (outs !== '0) begin fails++; $display("FAIL mid_reset_outs: got %b, required 0", outs); end
        wait_cyc(3);
        rst = 1'b0;
        r = cyc;
        exp_q.push_back('{r + 7, 0, 0});
        wait_cyc(9);
        compared++;
        if (btn_level !== 2'b01) begin fails++; $display("FAIL repress_level: got %b, required 01", btn_level); end
        btn[0] = 1'b1;
        exp_q.push_back('{r + 16, 1, 0});
        wait_cyc(10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_long_release_tie();
        test_back_to_back();
        test_reset_mid_press();
        wait_cyc(5);
        compared++;
        if (outs !== '0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_idle: got outs %b with %0d pending, required 0 and 0", outs, exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
        $finish;
    end
endmodule
